// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA counters, sync/blank and registered RGB driven by a pixel-clock enable.
// Optional VGA_FRAME_COUNT_EN adds a live 16-bit frame counter on frame_count (tied to zero otherwise).
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_DIV   = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  Red_in,
  input  logic [7:0]  Green_in,
  input  logic [7:0]  Blue_in,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        pixel_clk_en,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic [15:0] frame_count
);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  logic [DW-1:0] div_q, div_d;
  logic          en_q, en_d, fs_q, fs_d;
  logic [9:0]    hc_q, hc_d, vc_q, vc_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          h_wrap, v_wrap, visible;
  always_comb begin
    en_d    = div_q == DIV_LAST;
    div_d   = en_d ? '0 : div_q + 1'b1;
    h_wrap  = hc_q == H_LAST;
    v_wrap  = vc_q == V_LAST;
    hc_d    = en_q ? (h_wrap ? '0 : hc_q + 10'd1) : hc_q;
    vc_d    = (en_q && h_wrap) ? (v_wrap ? '0 : vc_q + 10'd1) : vc_q;
    fs_d    = en_q && h_wrap && v_wrap;
    visible = (hc_q < H_VIS) && (vc_q < V_VIS);
    // Sync, blank and colour all sample the same hc/vc so they stay one pixel behind DrawX/DrawY together.
    blank_d = en_q ? visible : blank_q;
    hs_d    = en_q ? !(hc_q >= HS_LO && hc_q <= HS_HI) : hs_q;
    vs_d    = en_q ? !(vc_q >= VS_LO && vc_q <= VS_HI) : vs_q;
    r_d     = en_q ? (visible ? Red_in : 8'd0) : r_q;
    g_d     = en_q ? (visible ? Green_in : 8'd0) : g_q;
    b_d     = en_q ? (visible ? Blue_in : 8'd0) : b_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q   <= '0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      div_q   <= div_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;
  always_comb frame_count_d = frame_count_q + {15'd0, fs_d};
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_count_q <= '0;
    else frame_count_q <= frame_count_d;
  end
  assign frame_count = frame_count_q;
`else
  assign frame_count = 16'h0000;
`endif
  assign DrawX        = hc_q;
  assign DrawY        = vc_q;
  assign pixel_clk_en = en_q;
  assign frame_start  = fs_q;
  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign VGA_BLANK_N  = blank_q;
  assign VGA_R        = r_q;
  assign VGA_G        = g_q;
  assign VGA_B        = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized run of vga_timing_gen (full-width lines, short frames) against an arithmetic pixel-index model.
module tb_vga_timing_gen;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 4, VF = 1, VS = 2, VB = 2;
  localparam int P = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;
  logic [9:0] draw_x, draw_y;
  logic pix_en, fs, hs, vs, blank_n;
  logic [7:0] vr, vg, vb;
  logic [15:0] fc;
  int vectors = 0, miscompares = 0;
  int e;
  logic m_blank, m_hs, m_vs, m_fs;
  logic [7:0] m_r, m_g, m_b;
  logic [15:0] m_fc;
  vga_timing_gen #(
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIX_DIV(P)
  ) u_dut (
    .Clk(clk), .Reset_n(rst_n), .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
    .DrawX(draw_x), .DrawY(draw_y), .pixel_clk_en(pix_en), .frame_start(fs),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .frame_count(fc)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask
  task automatic model_reset();
    e = 0;
    m_blank = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_fs = 1'b0;
    m_r = 8'd0; m_g = 8'd0; m_b = 8'd0; m_fc = 16'd0;
  endtask
  task automatic check_all();
    int s;
    s = (e >= 1) ? (e - 1) / P : 0;
    chk("pixel_clk_en", 32'(pix_en), 32'(e >= 1 && e % P == 0));
    chk("DrawX", 32'(draw_x), 32'(s % HT));
    chk("DrawY", 32'(draw_y), 32'((s / HT) % VT));
    chk("frame_start", 32'(fs), 32'(m_fs));
    chk("VGA_HS", 32'(hs), 32'(m_hs));
    chk("VGA_VS", 32'(vs), 32'(m_vs));
    chk("VGA_BLANK_N", 32'(blank_n), 32'(m_blank));
    chk("VGA_R", 32'(vr), 32'(m_r));
    chk("VGA_G", 32'(vg), 32'(m_g));
    chk("VGA_B", 32'(vb), 32'(m_b));
`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count", 32'(fc), 32'(m_fc));
`else
    chk("frame_count", 32'(fc), 32'd0);
`endif
  endtask
  // One Clk edge: the model consumes a pixel when the strobe was high before this edge.
  task automatic step(input bit rnd);
    int q, ph, pv;
    bit vis;
    @(posedge clk);
    e++;
    if (e >= 2 && (e - 1) % P == 0) begin
      q = (e - 1) / P - 1;
      ph = q % HT;
      pv = (q / HT) % VT;
      vis = ph < HV && pv < VV;
      m_blank = vis;
      m_hs = !(ph >= HV + HF && ph < HV + HF + HS);
      m_vs = !(pv >= VV + VF && pv < VV + VF + VS);
      m_r = vis ? r_in : 8'd0;
      m_g = vis ? g_in : 8'd0;
      m_b = vis ? b_in : 8'd0;
      m_fs = (q % FR) == FR - 1;
      if (m_fs) m_fc = m_fc + 16'd1;
    end else m_fs = 1'b0;
    #1;
    check_all();
    r_in = rnd ? 8'($urandom) : 8'hFF;
    g_in = rnd ? 8'($urandom) : 8'h55;
    b_in = rnd ? 8'($urandom) : 8'h00;
  endtask
  initial begin
    int s;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    r_in = 8'hFF; g_in = 8'h55; b_in = 8'h00;
    repeat (FR * P) step(1'b0);
`ifdef VGA_FRAME_COUNT_EN
    force u_dut.frame_count_q = 16'hFFFE;
    #1;
    release u_dut.frame_count_q;
    m_fc = 16'hFFFE;
`endif
    repeat (2 * FR * P + 200) step(1'b1);
    for (int k = 0; k < FR * P; k++) begin
      s = (e - 1) / P;
      if ((s % HT) == 300 && ((s / HT) % VT) == 2) break;
      step(1'b1);
    end
    chk("seek_x300", 32'(draw_x), 32'd300);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst_n = 1'b1;
    repeat (2 * HT * P) step(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the pixel coordinates (DrawX, DrawY) that the colour mapper consumes.
- Takes the colour mapper's combinational RGB back, registers it, and drives the VGA DAC pins with matching sync and blank.
- Fixed 640x480@60 timing from the 50 MHz board clock, using a pixel-clock enable rather than a derived clock.
- Sits between the top level and the colour mapper.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIX_DIV, 2, Clk cycles per pixel (>=1)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous reset, active low
- Red_in  in  8  red from colour mapper for current DrawX/DrawY
- Green_in  in  8  green from colour mapper
- Blue_in  in  8  blue from colour mapper
- DrawX  out  10  current horizontal counter, 0..H_TOTAL-1
- DrawY  out  10  current vertical counter, 0..V_TOTAL-1
- pixel_clk_en  out  1  one-Clk strobe per pixel
- frame_start  out  1  one-Clk pulse at the start of each frame
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  low outside the visible area
- VGA_R  out  8  red to DAC
- VGA_G  out  8  green to DAC
- VGA_B  out  8  blue to DAC

Behaviour:
- H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (async, Reset_n=0) values:
  - divider, hc and vc = 0
  - pixel_clk_en = 0, frame_start = 0
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0
  - VGA_R/G/B = 0
- On Reset_n deassertion, counting starts on the next Clk edge.
- Divider:
  - div counts 0..PIX_DIV-1 and wraps.
  - pixel_clk_en is registered and is high for exactly one Clk per PIX_DIV cycles.
  - The first strobe after reset occurs PIX_DIV Clk edges after release.
  - PIX_DIV=1 gives pixel_clk_en constantly high after the first edge.
- Counters advance only on Clk edges where pixel_clk_en=1:
  - hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps from V_TOTAL-1 to 0, only when hc also wraps.
  - DrawX=hc and DrawY=vc are direct register outputs, zero-extended to 10 bits.
- Pipeline stage (one pixel of latency), captured on the pixel_clk_en edge, all from the current hc/vc:
  - visible = (hc < H_VISIBLE) && (vc < V_VISIBLE)
  - VGA_BLANK_N <= visible
  - VGA_HS <= !(hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. hc 656..751 gives low
  - VGA_VS <= !(vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. vc 490..491 gives low
  - VGA_R/G/B <= visible ? *_in : 0; the DAC never sees colour during blanking.
  - Result: sync, blank and RGB stay mutually aligned, one pixel behind DrawX/DrawY.
- frame_start:
  - Registered and high for exactly one Clk, on the edge where hc goes 799->0 and vc goes 524->0.
  - It is not asserted by reset itself.
- Outputs are held steady between pixel_clk_en strobes.
- Reset mid-frame: all state returns to reset values immediately; the next frame restarts at (0,0) with no frame_start pulse.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined: adds output frame_count [15:0].
  - Reset value 0.
  - Increments on the Clk edge where frame_start is asserted; wraps 65535->0.
  - Used for blink and animation timing in the crossword UI.
- Not defined: the frame_count port still exists but is tied to 16'h0000, and no register is synthesised.

Test Plan:
- Reset held 5 Clk, then released, PIX_DIV=2 -> pixel_clk_en high on Clk edges 2,4,6...; DrawX=0,0,1,1,2...; VGA_BLANK_N=0 until the first strobe, then 1.
- Run one full line -> DrawX reaches 799 then 0, DrawY 0->1; VGA_HS low for exactly 96 strobes, first low strobe when DrawX=656 is captured (visible on the pin while DrawX=657).
- Run one full frame -> frame_start single 1-Clk pulse after 800*525*2 = 840000 Clk edges; VGA_VS low for 2 lines starting at captured DrawY=490.
- Red_in=FF, Green_in=55, Blue_in=00 constant -> VGA_R/G/B=FF/55/00 only while VGA_BLANK_N=1; 00/00/00 at DrawX=640..799 and DrawY=480..524.
- Assert Reset_n=0 at DrawX=300, DrawY=200 asynchronously -> all outputs at reset values before the next Clk edge; after release, counting resumes from (0,0).
- With VGA_FRAME_COUNT_EN: 3 frames -> frame_count 0->1->2->3; preload near 65535 via force -> wraps to 0. Without the macro: frame_count=0 throughout.
